bp_io_cmd_credit_arbiter: RTL and testbench
===========================================

# bp_io_cmd_credit_arbiter

Two-requester arbiter that shares a single CCE I/O command channel between the NBF stream loader (requester 0) and a host/debug command source (requester 1). It gates issue on an outstanding-command credit limit, holds its grant stable until the downstream network accepts, and routes in-order I/O responses back to the issuing requester through a tag FIFO. It sits between the loader/host command sources and the I/O network port of the core.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr/cce_block widths and derives cce_mem_msg_width_lp.
- max_credits_p, io_noc_max_credits_p: max outstanding commands; also the tag FIFO depth; must be ≥1.
- clk_i  in  1  sole clock, all state on posedge.
- reset_i  in  1  asynchronous, active-high reset.
- cmd0_i  in  cce_mem_msg_width_lp  loader command.
- cmd0_v_i  in  1  loader command valid.
- cmd0_yumi_o  out  1  loader command consumed.
- cmd1_i, cmd1_v_i, cmd1_yumi_o: same three for host.
- resp0_o  out  cce_mem_msg_width_lp  response to loader (io_resp_i passthrough).
- resp0_v_o  out  1;  resp0_ready_i  in  1.
- resp1_o, resp1_v_o, resp1_ready_i: same for host.
- io_cmd_o  out  cce_mem_msg_width_lp;  io_cmd_v_o  out  1;  io_cmd_yumi_i  in  1.
- io_resp_i  in  cce_mem_msg_width_lp;  io_resp_v_i  in  1;  io_resp_ready_o  out  1.
- credits_empty_o  out  1  no commands outstanding.
- resp_err_o  out  1  sticky: response received with no outstanding tag.

## Operation
- Arbiter states: IDLE, HOLD. IDLE: grant computed from cmd*_v_i per arbitration policy (see Configuration). io_cmd_v_o = v_i of granted requester & ~credits_full. If io_cmd_v_o & ~io_cmd_yumi_i → HOLD with grant registered. HOLD: grant fixed to registered requester, io_cmd_o/io_cmd_v_o from it; io_cmd_yumi_i → IDLE.
- Requesters must hold v_i and data until yumi; deassertion during HOLD is a protocol violation (unchecked).
- cmdN_yumi_o = io_cmd_yumi_i & grant==N. Only one yumi per cycle.
- Credit counter, width `BSG_WIDTH(max_credits_p)`: +1 on io_cmd_yumi_i, −1 on io_resp handshake; both same cycle → unchanged. credits_full = (count == max_credits_p). Never exceeds max or wraps below 0.
- Tag FIFO (1-bit requester id): push grant on io_cmd_yumi_i, pop on io_resp handshake. Credit gating guarantees no overflow.
- Response routing: head tag selects target; respN_v_o = io_resp_v_i & ~fifo_empty & head==N; io_resp_ready_o = fifo_empty | respN_ready_i of head target. Both resp*_o driven with io_resp_i.
- io_resp_v_i while FIFO empty: accepted and dropped, resp_err_o set until reset, counter unchanged.
- credits_empty_o = (count == 0).

## Timing
- Reset values: state IDLE, count 0, FIFO empty, RR pointer → requester 0, resp_err_o 0; hence io_cmd_v_o 0 only if no v_i, cmd*_yumi_o 0, resp*_v_o 0, io_resp_ready_o 1, credits_empty_o 1.
- Reset asserted mid-transfer: all state cleared immediately (asynchronously); an in-flight command's credit is discarded.
- Command path combinational: cmd→io_cmd zero-cycle latency; no bubble between back-to-back grants.
- Response path combinational, zero latency.
- A response popped in the same cycle a command is accepted while full: credit counter unchanged, but io_cmd_v_o uses registered count, so issue at full waits one cycle.

## Configuration
- BP_IO_CMD_ARB_RR_EN defined: round-robin; pointer toggles to other requester after each io_cmd_yumi_i.
- Undefined: fixed priority, requester 0 (loader) always wins in IDLE; host starves while loader valid.

## Structure
- Shared package: requester id enum (e_io_req_loader=0, e_io_req_host=1); arbiter state enum.
- One sub-module: bp_io_tag_fifo (depth max_credits_p, width 1, sync push/pop, async reset).
- Credit counter and arbitration inline.

## Test plan
- Reset, both idle → io_resp_ready_o=1, credits_empty_o=1, all valids 0.
- max_credits_p=2, loader issues 3 cmds, no resps → 2 yumis, then io_cmd_v_o=0; one resp → resp0_v_o=1, third cmd issues next cycle.
- Both valid every cycle, RR_EN, yumi always 1 → grants alternate 0,1,0,1; without RR_EN → grants all 0.
- Grant to host, io_cmd_yumi_i held 0 for 3 cycles while loader raises v → io_cmd_o stays host cmd (HOLD) until yumi.
- Interleaved issue host,loader,host; responses in order → resp1,resp0,resp1 with resp1_ready_i low one cycle stalling io_resp_ready_o.
- io_resp_v_i with nothing outstanding → dropped, resp_err_o=1 sticky, count stays 0; reset clears it.

Source files
------------

// File: rtl/bp_io_cmd_credit_arbiter_pkg.sv
// Shared types and helpers for the I/O command credit arbiter.
//   - bp_params_e / cce_mem_msg_width(): processor config and the CCE memory message width it implies
//   - bsg_width(): bits needed to count 0..x inclusive
//   - bp_io_req_e: requester id, also the value stored in the response tag FIFO
//   - bp_io_arb_state_e: arbiter state
package bp_io_cmd_credit_arbiter_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int unsigned default_paddr_width_lp     = 40;
    localparam int unsigned default_cce_block_width_lp = 64;
    // opcode, size, and other header fields that ride alongside addr/data
    localparam int unsigned default_msg_hdr_width_lp   = 16;

    function automatic int unsigned cce_mem_msg_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return default_msg_hdr_width_lp + default_paddr_width_lp
                                     + default_cce_block_width_lp;
            default:          return default_msg_hdr_width_lp + default_paddr_width_lp
                                     + default_cce_block_width_lp;
        endcase
    endfunction

    function automatic int unsigned bsg_width(int unsigned x);
        return $clog2(x + 1);
    endfunction

    typedef enum logic {
        e_io_req_loader = 1'b0,
        e_io_req_host   = 1'b1
    } bp_io_req_e;

    typedef enum logic {
        StIdle,
        StHold
    } bp_io_arb_state_e;

endpackage

// File: rtl/bp_io_tag_fifo.sv
// Requester-id FIFO recording which requester issued each outstanding I/O command, so
// in-order responses can be routed back.
// Ports:
//   clk_i, reset_i      clock, asynchronous active-high reset
//   push_i, data_i      enqueue requester id
//   pop_i               dequeue head (ignored when empty)
//   head_o, empty_o     head entry and empty flag
module bp_io_tag_fifo
    import bp_io_cmd_credit_arbiter_pkg::*;
#(
    parameter int unsigned els_p = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  bp_io_req_e data_i,
    input  logic       pop_i,
    output bp_io_req_e head_o,
    output logic       empty_o
);

    localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_width_lp = bsg_width(els_p);

    bp_io_req_e              mem_q [els_p];
    logic [ptr_width_lp-1:0] rd_ptr_q, wr_ptr_q;
    logic [cnt_width_lp-1:0] cnt_q;
    logic                    full, pop_ok, push_ok;

    function automatic logic [ptr_width_lp-1:0] next_ptr(logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == cnt_width_lp'(els_p));
    assign pop_ok  = pop_i & ~empty_o;
    // a simultaneous pop frees the slot the push needs
    assign push_ok = push_i & (~full | pop_ok);
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(els_p); i++) begin
                mem_q[i] <= e_io_req_loader;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + cnt_width_lp'(1);
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - cnt_width_lp'(1);
            end
        end
    end

endmodule

// File: rtl/bp_io_cmd_credit_arbiter.sv
// Shares one CCE I/O command channel between the NBF loader (requester 0) and a host/debug
// source (requester 1). Issue is gated by an outstanding-command credit limit, the grant is
// held until the network accepts, and in-order responses are routed back via a tag FIFO.
// Optional feature macro: BP_IO_CMD_ARB_RR_EN selects round-robin arbitration; otherwise the
// loader has fixed priority.
// Ports:
//   clk_i, reset_i                          clock, asynchronous active-high reset
//   cmdN_i / cmdN_v_i / cmdN_yumi_o         requester command channels (N = 0 loader, 1 host)
//   respN_o / respN_v_o / respN_ready_i     routed responses
//   io_cmd_o / io_cmd_v_o / io_cmd_yumi_i   command to the I/O network
//   io_resp_i / io_resp_v_i / io_resp_ready_o  response from the I/O network
//   credits_empty_o                         nothing outstanding
//   resp_err_o                              sticky: response arrived with nothing outstanding
module bp_io_cmd_credit_arbiter
    import bp_io_cmd_credit_arbiter_pkg::*;
#(
    parameter bp_params_e  bp_params_p          = e_bp_default_cfg,
    parameter int unsigned io_noc_max_credits_p = 2,
    parameter int unsigned max_credits_p        = io_noc_max_credits_p,
    localparam int unsigned cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic [cce_mem_msg_width_lp-1:0] cmd0_i,
    input  logic                            cmd0_v_i,
    output logic                            cmd0_yumi_o,
    input  logic [cce_mem_msg_width_lp-1:0] cmd1_i,
    input  logic                            cmd1_v_i,
    output logic                            cmd1_yumi_o,

    output logic [cce_mem_msg_width_lp-1:0] resp0_o,
    output logic                            resp0_v_o,
    input  logic                            resp0_ready_i,
    output logic [cce_mem_msg_width_lp-1:0] resp1_o,
    output logic                            resp1_v_o,
    input  logic                            resp1_ready_i,

    output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
    output logic                            io_cmd_v_o,
    input  logic                            io_cmd_yumi_i,

    input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
    input  logic                            io_resp_v_i,
    output logic                            io_resp_ready_o,

    output logic                            credits_empty_o,
    output logic                            resp_err_o
);

    localparam int unsigned cnt_width_lp = bsg_width(max_credits_p);

    bp_io_arb_state_e        state_q, state_d;
    bp_io_req_e              grant_q, grant_d;
    bp_io_req_e              idle_grant, grant;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    resp_err_q, resp_err_d;
    logic                    credits_full;
    logic                    fifo_empty, resp_pop;
    bp_io_req_e              head;

    // Arbitration
`ifdef BP_IO_CMD_ARB_RR_EN
    bp_io_req_e rr_ptr_q, rr_ptr_d;

    always_comb begin
        idle_grant = e_io_req_loader;
        if (cmd0_v_i && cmd1_v_i) begin
            idle_grant = rr_ptr_q;
        end else if (cmd1_v_i) begin
            idle_grant = e_io_req_host;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (io_cmd_yumi_i) begin
            rr_ptr_d = (grant == e_io_req_loader) ? e_io_req_host : e_io_req_loader;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q <= e_io_req_loader;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // fixed priority: the loader always wins, the host may starve
    always_comb begin
        idle_grant = e_io_req_loader;
        if (!cmd0_v_i && cmd1_v_i) begin
            idle_grant = e_io_req_host;
        end
    end
`endif

    assign grant        = (state_q == StHold) ? grant_q : idle_grant;
    // registered count only: a pop in the cycle we sit full does not let us issue until next cycle
    assign credits_full = (count_q == cnt_width_lp'(max_credits_p));

    assign io_cmd_o    = (grant == e_io_req_host) ? cmd1_i : cmd0_i;
    assign io_cmd_v_o  = ((grant == e_io_req_host) ? cmd1_v_i : cmd0_v_i) & ~credits_full;
    assign cmd0_yumi_o = io_cmd_yumi_i & (grant == e_io_req_loader);
    assign cmd1_yumi_o = io_cmd_yumi_i & (grant == e_io_req_host);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (io_cmd_v_o && !io_cmd_yumi_i) begin
                    state_d = StHold;
                    grant_d = grant;
                end
            end
            StHold: begin
                if (io_cmd_yumi_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Response routing
    assign resp0_o         = io_resp_i;
    assign resp1_o         = io_resp_i;
    assign resp0_v_o       = io_resp_v_i & ~fifo_empty & (head == e_io_req_loader);
    assign resp1_v_o       = io_resp_v_i & ~fifo_empty & (head == e_io_req_host);
    // with nothing outstanding, stray responses are swallowed rather than stalling the network
    assign io_resp_ready_o = fifo_empty
                           | ((head == e_io_req_host) ? resp1_ready_i : resp0_ready_i);
    assign resp_pop        = io_resp_v_i & io_resp_ready_o & ~fifo_empty;

    bp_io_tag_fifo #(
        .els_p (max_credits_p)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (io_cmd_yumi_i),
        .data_i  (grant),
        .pop_i   (resp_pop),
        .head_o  (head),
        .empty_o (fifo_empty)
    );

    // Credit counter
    always_comb begin
        count_d = count_q;
        if (io_cmd_yumi_i && !resp_pop && !credits_full) begin
            count_d = count_q + cnt_width_lp'(1);
        end else if (resp_pop && !io_cmd_yumi_i && (count_q != '0)) begin
            count_d = count_q - cnt_width_lp'(1);
        end
    end

    assign resp_err_d      = resp_err_q | (io_resp_v_i & fifo_empty);
    assign credits_empty_o = (count_q == '0);
    assign resp_err_o      = resp_err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            grant_q    <= e_io_req_loader;
            count_q    <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            count_q    <= count_d;
            resp_err_q <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_bp_io_cmd_credit_arbiter.sv
// Directed bench for bp_io_cmd_credit_arbiter with an outstanding-command queue model,
// a per-cycle compare process and hand-computed literal expectations.
module tb_bp_io_cmd_credit_arbiter;
    import bp_io_cmd_credit_arbiter_pkg::*;

    localparam int unsigned Max = 2;
    localparam int unsigned W   = cce_mem_msg_width(e_bp_default_cfg);

    localparam logic [W-1:0] CmdL  = W'(64'h1111_0000_0000_00A1);
    localparam logic [W-1:0] CmdH  = W'(64'h2222_0000_0000_00B2);
    localparam logic [W-1:0] CmdH2 = W'(64'h2222_0000_0000_00B3);
    localparam logic [W-1:0] Rsp1  = W'(64'h0000_5555_0000_0001);
    localparam logic [W-1:0] Rsp2  = W'(64'h0000_6666_0000_0002);
    localparam logic [W-1:0] Rsp3  = W'(64'h0000_7777_0000_0003);

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic [W-1:0] cmd0_i = '0, cmd1_i = '0;
    logic         cmd0_v_i = 1'b0, cmd1_v_i = 1'b0;
    logic         cmd0_yumi_o, cmd1_yumi_o;
    logic [W-1:0] resp0_o, resp1_o;
    logic         resp0_v_o, resp1_v_o;
    logic         resp0_ready_i = 1'b1, resp1_ready_i = 1'b1;
    logic [W-1:0] io_cmd_o;
    logic         io_cmd_v_o, io_cmd_yumi_i;
    logic [W-1:0] io_resp_i = '0;
    logic         io_resp_v_i = 1'b0;
    logic         io_resp_ready_o;
    logic         credits_empty_o, resp_err_o;
    logic         net_accept = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    // network accepts only what is offered
    assign io_cmd_yumi_i = net_accept & io_cmd_v_o;

    always #5 clk_i = ~clk_i;

    bp_io_cmd_credit_arbiter #(
        .bp_params_p          (e_bp_default_cfg),
        .io_noc_max_credits_p (Max)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .cmd0_i          (cmd0_i),
        .cmd0_v_i        (cmd0_v_i),
        .cmd0_yumi_o     (cmd0_yumi_o),
        .cmd1_i          (cmd1_i),
        .cmd1_v_i        (cmd1_v_i),
        .cmd1_yumi_o     (cmd1_yumi_o),
        .resp0_o         (resp0_o),
        .resp0_v_o       (resp0_v_o),
        .resp0_ready_i   (resp0_ready_i),
        .resp1_o         (resp1_o),
        .resp1_v_o       (resp1_v_o),
        .resp1_ready_i   (resp1_ready_i),
        .io_cmd_o        (io_cmd_o),
        .io_cmd_v_o      (io_cmd_v_o),
        .io_cmd_yumi_i   (io_cmd_yumi_i),
        .io_resp_i       (io_resp_i),
        .io_resp_v_i     (io_resp_v_i),
        .io_resp_ready_o (io_resp_ready_o),
        .credits_empty_o (credits_empty_o),
        .resp_err_o      (resp_err_o)
    );

    function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endfunction

    // Model: queue of requester ids for commands accepted but not yet answered (1 = host)
    bit m_q[$];
    bit m_hold = 1'b0;
    bit m_hg   = 1'b0;
    bit m_rr   = 1'b0;
    bit m_err  = 1'b0;

    function automatic bit m_grant();
        if (m_hold) return m_hg;
`ifdef BP_IO_CMD_ARB_RR_EN
        if (cmd0_v_i && cmd1_v_i) return m_rr;
        return cmd1_v_i && !cmd0_v_i;
`else
        return cmd1_v_i && !cmd0_v_i;
`endif
    endfunction

    function automatic bit m_vout();
        return (m_grant() ? cmd1_v_i : cmd0_v_i) && (m_q.size() < int'(Max));
    endfunction

    function automatic bit m_head_is(bit id);
        return (m_q.size() > 0) && (m_q[0] == id);
    endfunction

    function automatic bit m_ready();
        if (m_q.size() == 0) return 1'b1;
        return m_q[0] ? resp1_ready_i : resp0_ready_i;
    endfunction

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_q.delete();
            m_hold <= 1'b0;
            m_hg   <= 1'b0;
            m_rr   <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            // hold decision and grant use pre-update queue contents
            if (!io_cmd_yumi_i && m_vout()) begin
                m_hold <= 1'b1;
                m_hg   <= m_grant();
            end
            if (io_cmd_yumi_i) begin
                m_hold <= 1'b0;
                m_rr   <= !m_grant();
            end
            if (io_resp_v_i) begin
                if (m_q.size() == 0) m_err <= 1'b1;
                else if (m_ready()) void'(m_q.pop_front());
            end
            if (io_cmd_yumi_i) m_q.push_back(m_grant());
        end
    end

    always @(negedge clk_i) begin
        chk1("io_cmd_v", io_cmd_v_o, m_vout());
        if (m_vout()) chk("io_cmd", io_cmd_o, m_grant() ? cmd1_i : cmd0_i);
        chk1("cmd0_yumi", cmd0_yumi_o, net_accept && m_vout() && !m_grant());
        chk1("cmd1_yumi", cmd1_yumi_o, net_accept && m_vout() && m_grant());
        chk1("resp0_v", resp0_v_o, io_resp_v_i && m_head_is(1'b0));
        chk1("resp1_v", resp1_v_o, io_resp_v_i && m_head_is(1'b1));
        if (resp0_v_o) chk("resp0_data", resp0_o, io_resp_i);
        if (resp1_v_o) chk("resp1_data", resp1_o, io_resp_i);
        chk1("io_resp_ready", io_resp_ready_o, m_ready());
        chk1("credits_empty", credits_empty_o, m_q.size() == 0);
        chk1("resp_err", resp_err_o, m_err);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        cmd0_v_i   = 1'b0;
        cmd1_v_i   = 1'b0;
        net_accept = 1'b0;
        io_resp_v_i = 1'b0;
        resp0_ready_i = 1'b1;
        resp1_ready_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] pat;
        pat = '0;
        #1;
        do_reset();

        // reset state
        #1;
        chk1("rst_io_cmd_v", io_cmd_v_o, 1'b0);
        chk1("rst_resp_ready", io_resp_ready_o, 1'b1);
        chk1("rst_credits_empty", credits_empty_o, 1'b1);
        chk1("rst_resp0_v", resp0_v_o, 1'b0);
        chk1("rst_resp_err", resp_err_o, 1'b0);

        // credit limit: loader issues 3 with 2 credits
        tick();
        cmd0_v_i = 1'b1; cmd0_i = CmdL; net_accept = 1'b1;
        #1 chk1("lim_first_v", io_cmd_v_o, 1'b1);
        tick();
        tick();
        #1;
        chk1("lim_full_v", io_cmd_v_o, 1'b0);
        chk1("lim_full_not_empty", credits_empty_o, 1'b0);
        io_resp_v_i = 1'b1; io_resp_i = Rsp1;
        #1;
        chk1("lim_resp0_v", resp0_v_o, 1'b1);
        chk("lim_resp0_data", resp0_o, Rsp1);
        chk1("lim_pop_cycle_v", io_cmd_v_o, 1'b0);
        tick();
        io_resp_v_i = 1'b0;
        #1 chk1("lim_third_v", io_cmd_v_o, 1'b1);
        tick();
        cmd0_v_i = 1'b0; net_accept = 1'b0;
        io_resp_v_i = 1'b1;
        tick();
        tick();
        io_resp_v_i = 1'b0;
        #1 chk1("lim_drained", credits_empty_o, 1'b1);

        // both requesters valid every cycle
        do_reset();
        cmd0_v_i = 1'b1; cmd0_i = CmdL;
        cmd1_v_i = 1'b1; cmd1_i = CmdH;
        net_accept = 1'b1;
        for (int i = 0; i < 4; i++) begin
            io_resp_v_i = (i > 0);
            #1 pat[i] = cmd1_yumi_o;
            tick();
        end
        cmd0_v_i = 1'b0; cmd1_v_i = 1'b0; net_accept = 1'b0;
        io_resp_v_i = 1'b1;
        tick();
        io_resp_v_i = 1'b0;
`ifdef BP_IO_CMD_ARB_RR_EN
        chk("arb_pattern", W'(pat), W'(4'b1010));
`else
        chk("arb_pattern", W'(pat), W'(4'b0000));
`endif
        #1 chk1("arb_drained", credits_empty_o, 1'b1);

        // grant held on host while network stalls
        do_reset();
        cmd1_v_i = 1'b1; cmd1_i = CmdH;
        #1;
        chk1("hold_v", io_cmd_v_o, 1'b1);
        chk("hold_first", io_cmd_o, CmdH);
        tick();
        cmd0_v_i = 1'b1; cmd0_i = CmdL;
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_cmd", io_cmd_o, CmdH);
            tick();
        end
        net_accept = 1'b1;
        #1;
        chk1("hold_y1", cmd1_yumi_o, 1'b1);
        chk1("hold_y0", cmd0_yumi_o, 1'b0);
        tick();
        cmd1_v_i = 1'b0;
        #1;
        chk("hold_next", io_cmd_o, CmdL);
        chk1("hold_next_y0", cmd0_yumi_o, 1'b1);
        tick();
        cmd0_v_i = 1'b0; net_accept = 1'b0;
        // asynchronous reset with two commands outstanding
        #2 reset_i = 1'b1;
        #1;
        chk1("async_rst_empty", credits_empty_o, 1'b1);
        chk1("async_rst_ready", io_resp_ready_o, 1'b1);
        tick();
        reset_i = 1'b0;

        // interleaved host, loader, host with a stalled host response
        tick();
        net_accept = 1'b1;
        cmd1_v_i = 1'b1; cmd1_i = CmdH;
        tick();
        cmd1_v_i = 1'b0;
        cmd0_v_i = 1'b1; cmd0_i = CmdL;
        tick();
        cmd0_v_i = 1'b0; net_accept = 1'b0;
        io_resp_v_i = 1'b1; io_resp_i = Rsp1; resp1_ready_i = 1'b0;
        #1;
        chk1("il_r1_v", resp1_v_o, 1'b1);
        chk1("il_r0_v", resp0_v_o, 1'b0);
        chk1("il_stall", io_resp_ready_o, 1'b0);
        tick();
        resp1_ready_i = 1'b1;
        #1 chk1("il_unstall", io_resp_ready_o, 1'b1);
        tick();
        io_resp_v_i = 1'b0;
        cmd1_v_i = 1'b1; cmd1_i = CmdH2; net_accept = 1'b1;
        tick();
        cmd1_v_i = 1'b0; net_accept = 1'b0;
        io_resp_v_i = 1'b1; io_resp_i = Rsp2;
        #1;
        chk1("il_second_r0", resp0_v_o, 1'b1);
        chk1("il_second_r1", resp1_v_o, 1'b0);
        tick();
        io_resp_i = Rsp3;
        #1;
        chk1("il_third_r1", resp1_v_o, 1'b1);
        chk("il_third_data", resp1_o, Rsp3);
        tick();
        io_resp_v_i = 1'b0;
        #1 chk1("il_drained", credits_empty_o, 1'b1);

        // stray response with nothing outstanding
        tick();
        io_resp_v_i = 1'b1; io_resp_i = Rsp1;
        #1;
        chk1("stray_ready", io_resp_ready_o, 1'b1);
        chk1("stray_no_v0", resp0_v_o, 1'b0);
        tick();
        io_resp_v_i = 1'b0;
        #1;
        chk1("stray_err", resp_err_o, 1'b1);
        chk1("stray_count", credits_empty_o, 1'b1);
        tick();
        chk1("stray_sticky", resp_err_o, 1'b1);
        do_reset();
        #1 chk1("stray_cleared", resp_err_o, 1'b0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
